mips_boot_memory: RTL

Byte-wide unified instruction/data memory with a streaming program loader and a small memory-mapped I/O window. It sits directly downstream of the 8-bit multicycle MIPS core's memory port, receiving its `adr`, `memwrite` and `writedata` and returning `memdata`. After reset it holds the core in reset while a host streams a program image in over a valid/ready port, then releases the core to run.

---
 rtl/mips_boot_memory.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mips_boot_memory.sv
`default_nettype none
// ============================================================================
//  Module   : mips_boot_memory
//  Purpose  : Byte-wide unified instruction/data memory for the 8-bit
//             multicycle MIPS core. A host streams a program image in
//             over a valid/ready port while the core is held in reset.
//             After the image is loaded the core is released and runs
//             against the RAM plus a small memory-mapped I/O window.
//  Ports    : clk, reset              - system clock, sync active-high reset
//             adr, memwrite,
//             writedata, memdata      - core memory port (read is combinational)
//             ld_valid, ld_data,
//             ld_last, ld_ready       - program loader stream
//             cpu_reset               - reset driven into the core
//             led_out                 - MMIO output register at 0xFC
//  Map      : 0x00-0xFB RAM, 0xFC led_out (r/w), 0xFD cycle_cnt[7:0] (ro),
//             0xFE cycle_cnt[15:8] (ro), 0xFF ID byte 0xA5 (ro)
//  Revision : 1.0 - initial release
// ============================================================================
module mips_boot_memory (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] adr,
  input  logic       memwrite,
  input  logic [7:0] writedata,
  output logic [7:0] memdata,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  input  logic       ld_last,
  output logic       ld_ready,
  output logic       cpu_reset,
  output logic [7:0] led_out
);

  localparam logic [7:0] c_ram_top = 8'hFB;
  localparam logic [7:0] c_led_adr = 8'hFC;
  localparam logic [7:0] c_cnt_lo  = 8'hFD;
  localparam logic [7:0] c_cnt_hi  = 8'hFE;
  localparam logic [7:0] c_id_adr  = 8'hFF;
  localparam logic [7:0] c_id_val  = 8'hA5;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t      r_state;
  logic [7:0]  r_ld_ptr;
  logic [7:0]  r_led_out;
  logic [15:0] r_cycle_cnt;
  logic        r_ld_ready;

  // RAM is deliberately not reset: a reload after a mid-load reset only
  // overwrites the bytes it actually delivers.
  logic [7:0]  r_ram [0:251];

  logic        w_ld_xfer;
  logic        w_cpu_wr_ram;
  logic        w_cpu_wr_led;
  logic        w_ram_we;
  logic [7:0]  w_ram_adr;
  logic [7:0]  w_ram_din;

  assign w_ld_xfer    = (r_state == ST_LOAD) && ld_valid && r_ld_ready;
  assign w_cpu_wr_ram = (r_state == ST_RUN) && memwrite && (adr < c_led_adr);
  assign w_cpu_wr_led = (r_state == ST_RUN) && memwrite && (adr == c_led_adr);

  // Loader and core never write in the same state, so one shared port suffices.
  assign w_ram_we  = w_ld_xfer || w_cpu_wr_ram;
  assign w_ram_adr = w_ld_xfer ? r_ld_ptr : adr;
  assign w_ram_din = w_ld_xfer ? ld_data  : writedata;

  // Combinational so the core sees reset in the very cycle reset is raised.
  assign cpu_reset = reset || (r_state != ST_RUN);
  assign ld_ready  = r_ld_ready;
  assign led_out   = r_led_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_LOAD;
      r_ld_ptr    <= 8'h00;
      r_led_out   <= 8'h00;
      r_cycle_cnt <= 16'h0000;
      r_ld_ready  <= 1'b1;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_ld_xfer) begin
            r_ld_ptr <= r_ld_ptr + 8'd1;
            // The top RAM byte ends the load on its own so the pointer
            // can never run into the MMIO window.
            if (ld_last || (r_ld_ptr == c_ram_top)) begin
              r_state    <= ST_HOLD;
              r_ld_ready <= 1'b0;
            end
          end
        end
        ST_HOLD: begin
          r_state    <= ST_RUN;
          r_ld_ready <= 1'b0;
        end
        ST_RUN: begin
          r_cycle_cnt <= r_cycle_cnt + 16'd1;
          if (w_cpu_wr_led) begin
            r_led_out <= writedata;
          end
        end
        default: begin
          r_state    <= ST_LOAD;
          r_ld_ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_ram_we) begin
      r_ram[w_ram_adr] <= w_ram_din;
    end
  end

  // Read returns pre-edge contents, so read-during-write gives the old value.
  always_comb begin
    memdata = 8'h00;
    case (adr)
      c_led_adr: memdata = r_led_out;
      c_cnt_lo:  memdata = r_cycle_cnt[7:0];
      c_cnt_hi:  memdata = r_cycle_cnt[15:8];
      c_id_adr:  memdata = c_id_val;
      default:   memdata = r_ram[adr];
    endcase
  end

endmodule
`default_nettype wire
